cache_ctrl_2way_wb: RTL
=======================

# cache_ctrl_2way_wb

Parametrised 2-way set-associative cache controller with write-back, write-allocate policy, per-line dirty bits, per-set LRU replacement and saturating hit/miss counters. It sits between the RISC-V datapath's memory stage and the data memory, drives the cache data array's enables, and stalls the core while it resolves misses and dirty evictions. Tag, valid, dirty and LRU state live inside the block; the data array is external.

## Interface
Parameters:
- ADDR_W, 10, word-address width.
- INDEX_W, 5, set index width; 2^INDEX_W sets.
- OFFSET_W, 2, word-in-line offset width.
- CNT_W, 16, hit/miss counter width.
- Derived TAG_W = ADDR_W - INDEX_W - OFFSET_W; must be >= 1.

Ports:
- clock  in  1  single clock, all state updates on rising edge.
- reset  in  1  synchronous, active-high.
- address  in  ADDR_W  request address; held stable by the core while stall=1.
- MemRead  in  1  load request.
- MemWrite  in  1  store request; MemRead wins if both are high.
- ready  in  1  data memory transfer complete.
- stall  out  1  core must hold its request.
- index  out  INDEX_W  set index of the captured request.
- offset  out  OFFSET_W  word offset of the captured request.
- way  out  1  way targeted by the current cache array access.
- victim_tag  out  TAG_W  tag of the line being written back; forms the writeback address with index.
- MemRead_en, MemWrite_en  out  1  data memory line read / line write.
- CacheRead_en, CacheWrite_en  out  1  cache data array word read / line-or-word write.
- hit, miss  out  1  lookup result, valid only in COMPARE.
- hit_count, miss_count  out  CNT_W  saturating counters.

## Operation
- States: IDLE, COMPARE, WRITEBACK, FILL.
- IDLE: if MemRead|MemWrite, capture address and op into request registers, go to COMPARE. stall=1 in that cycle.
- COMPARE: hit = valid && tag match in either way; way = hitting way.
  - Read hit: CacheRead_en=1, stall=0, lru[set] <= ~way, hit_count++, go to IDLE.
  - Write hit: CacheWrite_en=1 (word write), dirty[set][way] <= 1, stall=0, LRU updated, hit_count++, go to IDLE.
  - Miss: stall=1, miss_count++. Victim is way 0 if invalid, else way 1 if invalid, else lru[set]. If victim is valid and dirty, go to WRITEBACK; otherwise go to FILL.
- WRITEBACK: MemWrite_en=1, victim_tag=tags[set][victim], way=victim, stall=1. On ready, clear dirty[set][victim] and go to FILL.
- FILL: MemRead_en=1, way=victim, stall=1. On ready, CacheWrite_en=1 (line fill), valid <= 1, tag <= request tag, dirty <= 0, go to COMPARE. The re-lookup hits and completes the op. A write miss becomes a write hit and sets dirty.
- Counters saturate at all-ones and count only COMPARE-cycle outcomes. The post-fill re-lookup is not counted as a hit.
- Outputs not named above are 0 in each state.

## Timing
- Reset: state IDLE. All valid, dirty and lru bits are 0. Counters are 0. All outputs are 0; index, offset and victim_tag read 0.
- Reset mid-operation (any state) aborts the transfer and returns to IDLE on the next edge. There is no flush; dirty data is lost by design.
- Hit latency: 2 cycles (IDLE capture + COMPARE). stall falls in the COMPARE cycle.
- Clean miss: 2 + fill cycles + 1 re-lookup. Dirty miss adds the writeback cycles.
- ready is sampled only while MemRead_en or MemWrite_en is high. If ready is high on the first cycle of WRITEBACK or FILL, that transfer completes in a single cycle.
- Requests arriving in non-IDLE states are ignored. The core holds them under stall.

## Test plan
- Cold read 0x084 (tag 1, set 1): COMPARE miss, FILL way 0, ready after 3 cycles, re-lookup hit. Result miss_count=1, hit_count=0. Repeat read: hit in 2 cycles, hit_count=1.
- Write 0x085 after the fill: CacheWrite_en=1, MemWrite_en never asserted, stall low in COMPARE. Set 1 way 0 becomes dirty.
- Read 0x104 fills way 1. Then read 0x184: victim way 0 (LRU), WRITEBACK with victim_tag=1 and MemWrite_en held until ready, then FILL. Re-read 0x104 hits way 1.
- Assert reset during FILL of 0x084: next cycle state IDLE, all outputs 0. A subsequent read 0x084 misses.
- MemRead=MemWrite=1 at 0x200: treated as a read. Write miss to 0x300 fills, then re-lookup sets dirty with exactly one CacheWrite_en line fill and one word write.
- CNT_W=2: 5 misses leave miss_count=3 (saturated).

Source files
------------

// File: rtl/cache_ctrl_2way_wb_if.sv
// cache_ctrl_2way_wb_if: core, memory and data-array signals of the 2-way write-back cache controller.
interface cache_ctrl_2way_wb_if #(
    parameter int ADDR_W   = 10,
    parameter int INDEX_W  = 5,
    parameter int OFFSET_W = 2,
    parameter int CNT_W    = 16
) ();
    localparam int TAG_W = ADDR_W - INDEX_W - OFFSET_W;
    logic [ADDR_W-1:0]   address;
    logic                MemRead;
    logic                MemWrite;
    logic                ready;
    logic                stall;
    logic [INDEX_W-1:0]  index;
    logic [OFFSET_W-1:0] offset;
    logic                way;
    logic [TAG_W-1:0]    victim_tag;
    logic                MemRead_en;
    logic                MemWrite_en;
    logic                CacheRead_en;
    logic                CacheWrite_en;
    logic                hit;
    logic                miss;
    logic [CNT_W-1:0]    hit_count;
    logic [CNT_W-1:0]    miss_count;
    modport master (
        output address, MemRead, MemWrite, ready,
        input  stall, index, offset, way, victim_tag, MemRead_en, MemWrite_en,
               CacheRead_en, CacheWrite_en, hit, miss, hit_count, miss_count
    );
    modport slave (
        input  address, MemRead, MemWrite, ready,
        output stall, index, offset, way, victim_tag, MemRead_en, MemWrite_en,
               CacheRead_en, CacheWrite_en, hit, miss, hit_count, miss_count
    );
endinterface

// File: rtl/cache_ctrl_2way_wb.sv
// cache_ctrl_2way_wb: 2-way set-associative write-back/write-allocate cache controller with LRU and hit/miss counters.
module cache_ctrl_2way_wb #(
    parameter int ADDR_W   = 10,
    parameter int INDEX_W  = 5,
    parameter int OFFSET_W = 2,
    parameter int CNT_W    = 16
) (
    input logic clk,
    input logic rst,
    cache_ctrl_2way_wb_if.slave bus
);
    localparam int TAG_W = ADDR_W - INDEX_W - OFFSET_W;
    localparam int SETS  = 1 << INDEX_W;
    typedef enum logic [1:0] {IDLE, COMPARE, WRITEBACK, FILL} state_t;
    state_t state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic write_q, write_d;
    logic victim_q, victim_d;
    logic refill_q, refill_d;
    logic [TAG_W-1:0] tag_q [2][SETS];
    logic [1:0][SETS-1:0] valid_q, dirty_q;
    logic [SETS-1:0] lru_q;
    logic [CNT_W-1:0] hit_cnt_q, miss_cnt_q;
    logic [INDEX_W-1:0] set;
    logic [TAG_W-1:0] req_tag;
    logic [1:0] match;
    logic hit_way, victim;
    assign set      = addr_q[OFFSET_W +: INDEX_W];
    assign req_tag  = addr_q[ADDR_W-1 -: TAG_W];
    assign match[0] = valid_q[0][set] && tag_q[0][set] == req_tag;
    assign match[1] = valid_q[1][set] && tag_q[1][set] == req_tag;
    assign hit_way  = ~match[0];
    // Fill empty ways first, then evict the least recently used one.
    assign victim   = !valid_q[0][set] ? 1'b0 : !valid_q[1][set] ? 1'b1 : lru_q[set];
    assign bus.index      = set;
    assign bus.offset     = addr_q[OFFSET_W-1:0];
    assign bus.hit_count  = hit_cnt_q;
    assign bus.miss_count = miss_cnt_q;
    always_comb begin
        state_d           = state_q;
        addr_d            = addr_q;
        write_d           = write_q;
        victim_d          = victim_q;
        refill_d          = refill_q;
        bus.stall         = 1'b0;
        bus.way           = 1'b0;
        bus.victim_tag    = '0;
        bus.MemRead_en    = 1'b0;
        bus.MemWrite_en   = 1'b0;
        bus.CacheRead_en  = 1'b0;
        bus.CacheWrite_en = 1'b0;
        bus.hit           = 1'b0;
        bus.miss          = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.MemRead || bus.MemWrite) begin
                    bus.stall = 1'b1;
                    addr_d    = bus.address;
                    write_d   = ~bus.MemRead;
                    refill_d  = 1'b0;
                    state_d   = COMPARE;
                end
            end
            COMPARE: begin
                bus.hit  = |match;
                bus.miss = ~|match;
                if (|match) begin
                    bus.way           = hit_way;
                    bus.CacheRead_en  = ~write_q;
                    bus.CacheWrite_en = write_q;
                    refill_d          = 1'b0;
                    state_d           = IDLE;
                end else begin
                    bus.stall = 1'b1;
                    victim_d  = victim;
                    state_d   = valid_q[victim][set] && dirty_q[victim][set] ? WRITEBACK : FILL;
                end
            end
            WRITEBACK: begin
                bus.stall       = 1'b1;
                bus.MemWrite_en = 1'b1;
                bus.way         = victim_q;
                bus.victim_tag  = tag_q[victim_q][set];
                state_d         = bus.ready ? FILL : WRITEBACK;
            end
            FILL: begin
                bus.stall         = 1'b1;
                bus.MemRead_en    = 1'b1;
                bus.way           = victim_q;
                bus.CacheWrite_en = bus.ready;
                refill_d          = bus.ready;
                state_d           = bus.ready ? COMPARE : FILL;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            write_q    <= 1'b0;
            victim_q   <= 1'b0;
            refill_q   <= 1'b0;
            valid_q    <= '0;
            dirty_q    <= '0;
            lru_q      <= '0;
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            write_q  <= write_d;
            victim_q <= victim_d;
            refill_q <= refill_d;
            if (bus.hit) begin
                lru_q[set] <= ~hit_way;
                if (write_q) dirty_q[hit_way][set] <= 1'b1;
                if (!refill_q && hit_cnt_q != '1) hit_cnt_q <= hit_cnt_q + CNT_W'(1);
            end
            if (bus.miss && miss_cnt_q != '1) miss_cnt_q <= miss_cnt_q + CNT_W'(1);
            if (state_q == WRITEBACK && bus.ready) dirty_q[victim_q][set] <= 1'b0;
            if (state_q == FILL && bus.ready) begin
                valid_q[victim_q][set] <= 1'b1;
                dirty_q[victim_q][set] <= 1'b0;
                tag_q[victim_q][set]   <= req_tag;
            end
        end
    end
endmodule
